// File: rtl/moonbase_bus_responder_if.sv
// Bus bundle between the 8-bit CPU side (CPU, device decode, program loader)
// and the moonbase target-side responder.
interface moonbase_bus_responder_if #(
    parameter int AW = 6
);
    logic [7:0]  bus_out;
    logic [3:0]  ram_in;
    logic [1:0]  data_in;
    logic [11:0] dev_addr;
    logic [1:0]  dev_rd_data;
    logic        dev_wr_stb;
    logic        dev_wr_nib;
    logic [3:0]  dev_wr_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [AW:0] ld_addr;
    logic [3:0]  ld_data;

    modport master (
        output bus_out, dev_rd_data, ld_valid, ld_addr, ld_data,
        input  ram_in, data_in, dev_addr, dev_wr_stb, dev_wr_nib, dev_wr_data, ld_ready
    );

    modport slave (
        input  bus_out, dev_rd_data, ld_valid, ld_addr, ld_data,
        output ram_in, data_in, dev_addr, dev_wr_stb, dev_wr_nib, dev_wr_data, ld_ready
    );
endinterface

// File: rtl/moonbase_bus_responder.sv
// Target side of the 8-bit CPU external bus: address latch, nibble SRAM with a
// loader port, device write/read port and a sticky protocol checker.
module moonbase_bus_responder #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    moonbase_bus_responder_if.slave  bus,
    output logic                     err,
    input  logic                     err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [11:0] addr_r;
    logic [3:0]  mem_r [0:2*DEPTH-1];
    logic        err_r;
    logic        err_set_s;
    logic        strobe_s;
    logic        nib_s;
    logic        ram_we_s;
    logic        dev_we_s;
    logic        we_any_s;
    logic        ld_fire_s;
    logic [AW:0] rd_idx_s;

    // Bus field decode; the loader only owns the array port when the bus is not writing it.
    always_comb begin
        strobe_s  = bus.bus_out[7];
        nib_s     = bus.bus_out[6];
        ram_we_s  = ~strobe_s & ~bus.bus_out[5];
        dev_we_s  = ~strobe_s & ~bus.bus_out[4];
        we_any_s  = ram_we_s | dev_we_s;
        rd_idx_s  = {addr_r[AW-1:0], nib_s};
        ld_fire_s = bus.ld_valid & ~ram_we_s & reset_n;
    end

    assign bus.dev_addr = addr_r;
    assign bus.ld_ready = reset_n & ~ram_we_s;
    assign err          = err_r;

    // Zero-latency read path: the CPU samples ram_in/data_in at the edge closing this cycle.
    always_comb begin
        if (strobe_s) begin
            bus.ram_in  = 4'h0;
            bus.data_in = 2'b00;
        end else begin
            bus.ram_in  = mem_r[rd_idx_s];
            bus.data_in = bus.dev_rd_data;
        end
    end

    // Device write strobe, held low while in reset.
    always_comb begin
        if (reset_n && dev_we_s) begin
            bus.dev_wr_stb  = 1'b1;
            bus.dev_wr_nib  = nib_s;
            bus.dev_wr_data = bus.bus_out[3:0];
        end else begin
            bus.dev_wr_stb  = 1'b0;
            bus.dev_wr_nib  = 1'b0;
            bus.dev_wr_data = 4'h0;
        end
    end

    // 12-bit address latch, loaded six bits at a time by strobe cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= 12'h000;
        end else if (strobe_s) begin
            if (nib_s) begin
                addr_r[11:6] <= bus.bus_out[5:0];
            end else begin
                addr_r[5:0] <= bus.bus_out[5:0];
            end
        end
    end

    // Nibble array; contents survive reset so a preloaded program is kept.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[rd_idx_s] <= bus.bus_out[3:0];
        end else if (ld_fire_s) begin
            mem_r[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Protocol state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Protocol next state and error detection; a write before a full address is an error.
    always_comb begin
        state_nx_s = state_r;
        err_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (strobe_s) begin
                    if (nib_s) begin
                        err_set_s = 1'b1;
                    end else begin
                        state_nx_s = ST_LO;
                    end
                end else begin
                    err_set_s = we_any_s;
                end
            end
            ST_LO: begin
                if (strobe_s) begin
                    if (nib_s) begin
                        state_nx_s = ST_ADDR;
                    end else begin
                        state_nx_s = ST_LO;
                    end
                end else begin
                    err_set_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (strobe_s) begin
                    if (nib_s) begin
                        err_set_s  = 1'b1;
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_LO;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sticky error flag; a new error in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moonbase_bus_responder.sv
// Table-driven bench for moonbase_bus_responder: each vector is queued as the
// expected record when driven and compared when the outputs are sampled.
module tb_moonbase_bus_responder;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic reset_n;
    logic err;
    logic err_clr;

    moonbase_bus_responder_if #(.AW(AW)) bif ();

    moonbase_bus_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif),
        .err     (err),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic [7:0]  bus;
        logic        ldv;
        logic [6:0]  lda;
        logic [3:0]  ldd;
        logic [1:0]  drd;
        logic        clr;
        logic        chk_ram;
        logic [3:0]  e_ram;
        logic [1:0]  e_din;
        logic        e_stb;
        logic        e_nib;
        logic [3:0]  e_wd;
        logic        e_rdy;
        logic        e_err;
        logic [11:0] e_addr;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic rstn, input logic [7:0] bus, input logic ldv,
                                input logic [6:0] lda, input logic [3:0] ldd, input logic [1:0] drd,
                                input logic clr, input logic ck, input logic [3:0] er,
                                input logic [1:0] ed, input logic es, input logic en,
                                input logic [3:0] ew, input logic ey, input logic ee,
                                input logic [11:0] ea);
        vec_t v;
        v.rstn = rstn; v.bus = bus; v.ldv = ldv; v.lda = lda; v.ldd = ldd; v.drd = drd;
        v.clr = clr; v.chk_ram = ck; v.e_ram = er; v.e_din = ed; v.e_stb = es;
        v.e_nib = en; v.e_wd = ew; v.e_rdy = ey; v.e_err = ee; v.e_addr = ea;
        return v;
    endfunction

    task automatic check(input int idx, input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL vec%0d %s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] ld_vals [8];
        vec_t       d;
        vec_t       e;

        ld_vals[0] = 4'hF; ld_vals[1] = 4'h0; ld_vals[2] = 4'h4; ld_vals[3] = 4'h2;
        ld_vals[4] = 4'h7; ld_vals[5] = 4'h1; ld_vals[6] = 4'hA; ld_vals[7] = 4'hB;

        reset_n         = 1'b0;
        err_clr         = 1'b0;
        bif.bus_out     = 8'h30;
        bif.dev_rd_data = 2'b00;
        bif.ld_valid    = 1'b0;
        bif.ld_addr     = 7'd0;
        bif.ld_data     = 4'h0;

        //            rstn  bus    ldv   lda    ldd   drd    clr   ck    ram   din    stb   nib   wd    rdy   err   addr
        tbl.push_back(mk(1'b0, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h000));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1'b1, 8'h30, 1'b1, 7'(i), ld_vals[i], 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        end
        // read nibbles 0/1 of byte 0
        tbl.push_back(mk(1'b1, 8'h80, 1'b0, 7'd0,  4'h0, 2'b01, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b01, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'h30, 1'b0, 7'd0,  4'h0, 2'b01, 1'b0, 1'b1, 4'hF, 2'b01, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'h70, 1'b0, 7'd0,  4'h0, 2'b01, 1'b0, 1'b1, 4'h0, 2'b01, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        // write 5/C to byte 3, read-before-write shows old A/B, then read back
        tbl.push_back(mk(1'b1, 8'h83, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h003));
        tbl.push_back(mk(1'b1, 8'h15, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hA, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h003));
        tbl.push_back(mk(1'b1, 8'h5C, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hB, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h003));
        tbl.push_back(mk(1'b1, 8'h83, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h003));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h003));
        tbl.push_back(mk(1'b1, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h5, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h003));
        tbl.push_back(mk(1'b1, 8'h70, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hC, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h003));
        // address 0xFFF wraps onto byte 0x3F
        tbl.push_back(mk(1'b1, 8'hBF, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h003));
        tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h03F));
        tbl.push_back(mk(1'b1, 8'h19, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'hFFF));
        tbl.push_back(mk(1'b1, 8'h56, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'hFFF));
        tbl.push_back(mk(1'b1, 8'hBF, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'hFFF));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'hFFF));
        tbl.push_back(mk(1'b1, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h9, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h03F));
        tbl.push_back(mk(1'b1, 8'h70, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h6, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h03F));
        // device writes at 0x081, device read value passed through on data cycles only
        tbl.push_back(mk(1'b1, 8'h81, 1'b0, 7'd0,  4'h0, 2'b10, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h03F));
        tbl.push_back(mk(1'b1, 8'hC2, 1'b0, 7'd0,  4'h0, 2'b10, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h001));
        tbl.push_back(mk(1'b1, 8'h2A, 1'b0, 7'd0,  4'h0, 2'b10, 1'b0, 1'b1, 4'h4, 2'b10, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 12'h081));
        tbl.push_back(mk(1'b1, 8'h63, 1'b0, 7'd0,  4'h0, 2'b10, 1'b0, 1'b1, 4'h2, 2'b10, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 12'h081));
        // loader collides with a bus RAM write, lands one cycle later
        tbl.push_back(mk(1'b1, 8'h85, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h081));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h085));
        tbl.push_back(mk(1'b1, 8'h17, 1'b1, 7'd11, 4'hD, 2'b00, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h005));
        tbl.push_back(mk(1'b1, 8'h30, 1'b1, 7'd11, 4'hD, 2'b00, 1'b0, 1'b1, 4'h7, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h005));
        tbl.push_back(mk(1'b1, 8'h70, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hD, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h005));
        // protocol errors, sticky flag, clear, set-wins, reset mid-ADDR
        tbl.push_back(mk(1'b0, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'h80, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 12'h000));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 12'h000));
        tbl.push_back(mk(1'b1, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 12'h000));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b00, 1'b1, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 12'h000));
        tbl.push_back(mk(1'b1, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b1, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 12'h000));
        tbl.push_back(mk(1'b1, 8'h85, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h7, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h005));
        tbl.push_back(mk(1'b1, 8'h85, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 12'h005));
        tbl.push_back(mk(1'b1, 8'hC1, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 12'h005));
        tbl.push_back(mk(1'b0, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'h80, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'hC0, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'h30, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'h70, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 12'h000));
        // device write suppressed in reset, then flagged as an error from IDLE
        tbl.push_back(mk(1'b0, 8'h2F, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hF, 2'b00, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'h2F, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'hF, 2'b00, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 12'h000));
        tbl.push_back(mk(1'b1, 8'hA5, 1'b0, 7'd0,  4'h0, 2'b00, 1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 12'h000));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            d               = tbl[i];
            reset_n         = d.rstn;
            bif.bus_out     = d.bus;
            bif.ld_valid    = d.ldv;
            bif.ld_addr     = d.lda;
            bif.ld_data     = d.ldd;
            bif.dev_rd_data = d.drd;
            err_clr         = d.clr;
            exp_q.push_back(d);
            #1;
            e = exp_q.pop_front();
            if (e.chk_ram) check(i, "ram_in", {8'd0, bif.ram_in}, {8'd0, e.e_ram});
            check(i, "data_in",     {10'd0, bif.data_in},    {10'd0, e.e_din});
            check(i, "dev_wr_stb",  {11'd0, bif.dev_wr_stb}, {11'd0, e.e_stb});
            check(i, "dev_wr_nib",  {11'd0, bif.dev_wr_nib}, {11'd0, e.e_nib});
            check(i, "dev_wr_data", {8'd0, bif.dev_wr_data}, {8'd0, e.e_wd});
            check(i, "ld_ready",    {11'd0, bif.ld_ready},   {11'd0, e.e_rdy});
            check(i, "err",         {11'd0, err},            {11'd0, e.e_err});
            check(i, "dev_addr",    bif.dev_addr,            e.e_addr);
        end

        // Reset asserted between clock edges takes effect without a clock.
        @(posedge clk);
        #2;
        check(900, "err_before_async_reset",  {11'd0, err}, 12'h001);
        check(900, "addr_before_async_reset", bif.dev_addr, 12'h025);
        reset_n = 1'b0;
        #1;
        check(901, "err_async_reset",      {11'd0, err},          12'h000);
        check(901, "addr_async_reset",     bif.dev_addr,          12'h000);
        check(901, "ld_ready_async_reset", {11'd0, bif.ld_ready}, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check(902, "ld_ready_after_release", {11'd0, bif.ld_ready}, 12'h001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/moonbase_bus_responder.md
Name: moonbase_bus_responder

Overview:
- Target-side model of the 8-bit CPU external bus: the address latch, the nibble-wide SRAM and the device port, as one synthesizable block.
- Consumes the CPU's 8-bit bus output (strobe, nibble, address/data/write enables) and produces the CPU's read inputs (ram_in nibble, 2-bit device read).
- Includes a program loader port for preloading memory before or while the CPU runs, and a protocol-checking FSM.
- Used for on-die demo and for bench co-simulation with the CPU.

Parameters:
- DEPTH, 64, number of bytes of SRAM; each byte is two nibbles; power of two, 2..2048.
- AW, $clog2(DEPTH), byte address bits used for SRAM indexing.

Ports:
- clk  in  1  rising-edge clock, same clock as the CPU.
- reset_n  in  1  asynchronous, active-low reset.
- bus_out  in  8  CPU bus output: [7] strobe, [6] nibble, [5:0] address portion when strobe=1; when strobe=0: [5] ram_we_n, [4] dev_we_n, [3:0] write data.
- ram_in  out  4  SRAM read nibble, to the CPU's io_in[5:2].
- data_in  out  2  device read bits, to the CPU's io_in[7:6].
- dev_addr  out  12  latched 12-bit address, for device decode.
- dev_rd_data  in  2  device read value for dev_addr; passed through to data_in.
- dev_wr_stb  out  1  one-cycle pulse per device nibble write.
- dev_wr_nib  out  1  nibble select of that write (0 = high nibble).
- dev_wr_data  out  4  write data of that write.
- ld_valid  in  1  loader request.
- ld_ready  out  1  loader accept.
- ld_addr  in  AW+1  nibble address; the LSB is the nibble select.
- ld_data  in  4  loader nibble.
- err  out  1  sticky protocol error.
- err_clr  in  1  synchronous clear of err.

Behaviour:
Address latch:
- Updated on clk when strobe=1: nibble=0 loads addr[5:0] from bus_out[5:0]; nibble=1 loads addr[11:6].
- Reset value of addr is 0. dev_addr = addr.

SRAM:
- Array of 2*DEPTH nibbles, indexed by {addr[AW-1:0], nibble}; nibble 0 is the high nibble of the byte.
- Addresses wrap modulo DEPTH; addr[11:AW] is ignored.
- Array contents are not reset.
- Reads are asynchronous: ram_in = mem[{addr[AW-1:0], bus_out[6]}] in every cycle with strobe=0. ram_in = 0 when strobe=1.
- Zero-cycle read latency: the CPU samples ram_in on the edge ending that cycle.

RAM write:
- Occurs on clk when strobe=0 and bus_out[5]=0: mem[{addr, bus_out[6]}] <= bus_out[3:0].

Device port:
- data_in = dev_rd_data when strobe=0, else 0.
- When strobe=0 and bus_out[4]=0: dev_wr_stb=1 for exactly that cycle, with dev_wr_nib = bus_out[6] and dev_wr_data = bus_out[3:0].
- dev_wr_stb, dev_wr_nib and dev_wr_data are combinational from bus_out. All are 0 in reset and when strobe=1.

Loader:
- ld_ready = !(strobe=0 && ram_we_n=0) && reset_n.
- A transfer completes when ld_valid && ld_ready at a clk edge: mem[ld_addr] <= ld_data.
- A bus RAM write always wins the port. The loader holds ld_valid and its data until accepted.

Protocol FSM (states IDLE, LO, ADDR, DATA; reset state IDLE):
- IDLE: strobe&nibble=0 -> LO; strobe&nibble=1 -> err, stay IDLE; strobe=0 -> stay.
- LO: strobe&nibble=1 -> ADDR; strobe&nibble=0 -> LO; strobe=0 -> err, IDLE.
- ADDR: strobe=0 -> DATA; strobe&nibble=0 -> LO; strobe&nibble=1 -> err, IDLE.
- DATA: strobe=0 -> DATA (a CPU read sequence spans up to 2 data cycles); strobe&nibble=0 -> LO; strobe&nibble=1 -> err, IDLE.
- Any write enable (bus_out[5]=0 or bus_out[4]=0, strobe=0) in IDLE or LO -> err.

Error flag:
- err is sticky; reset value 0.
- If err_clr and a new error occur in the same cycle, err stays 1 (set wins).

Other boundary rules:
- Simultaneous ram_we_n=0 and dev_we_n=0: both writes happen; no error.
- Reset asserted mid-sequence: FSM -> IDLE, addr -> 0, err -> 0, ld_ready -> 0. Memory is retained.

Test Plan:
1. Loader writes nibbles 0x0..0x7 = F,0,4,2,7,1,A,B. Then drive strobe addr lo=0, hi=0, then two data cycles with nibble 0/1 -> ram_in = F then 0; err=0.
2. Drive strobe addr lo=0x03, hi=0x00, then data cycles ram_we_n=0 with data 5 (nibble 0) and C (nibble 1). Read back with a new strobe of the same address -> ram_in = 5, C; mem[6]=5, mem[7]=C.
3. Drive lo=0x3F, hi=0x3F (addr 0xFFF, DEPTH=64) and write 9/6. Read addr 0x03F -> 9, 6 (wrap); dev_addr = 0xFFF during the write.
4. Drive addr 0x081 with dev_we_n=0, data 0xA then 0x3 -> dev_wr_stb pulses on 2 consecutive cycles, nib 0 then 1, data A then 3. Hold dev_rd_data=2'b10 -> data_in=2'b10 in data cycles, 0 in strobe cycles.
5. Assert ld_valid while the bus does a RAM write -> ld_ready=0 that cycle; the load lands the next cycle; both values are correct on readback.
6. Strobe nibble=1 from IDLE -> err=1 and stays after further legal traffic. Pulse err_clr -> err=0. Assert reset_n=0 mid-ADDR -> err=0, addr=0, FSM IDLE; subsequent legal access OK.
